// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM state encoding and owner tags.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } state_e;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

endpackage

// File: rtl/dmem_arb_pick.sv
// Requester pick: fixed CPU priority with a starvation counter that forces a DMA grant
// after STARVE_LIMIT consecutive CPU grants while DMA waits.
module dmem_arb_pick #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic accept_en,
  input  logic cpu_req_valid,
  input  logic dma_req_valid,
  output logic grant_cpu,
  output logic grant_dma
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       dma_wins;

  always_comb begin
    // NOTE: every output gets a default before any branch, so no path leaves a latch.
    dma_wins     = dma_req_valid && (!cpu_req_valid || (starve_cnt_q == LIMIT));
    grant_dma    = accept_en && dma_wins;
    grant_cpu    = accept_en && cpu_req_valid && !dma_wins;
    starve_cnt_d = starve_cnt_q;
    if (!dma_req_valid || grant_dma) begin
      starve_cnt_d = '0;
    end else if (grant_cpu && (starve_cnt_q != LIMIT)) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  // NOTE: clocked state uses non-blocking assignment so all flops sample the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single-port data memory: accept -> access -> respond.
// Define DMEM_ARB_MISALIGN_CHK_EN to block misaligned accesses and flag them with resp_err.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W       = 9,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req_valid,
  output logic              cpu_req_ready,
  input  logic              cpu_req_we,
  input  logic [ADDR_W-1:0] cpu_req_addr,
  input  logic [DATA_W-1:0] cpu_req_wdata,
  output logic              cpu_resp_valid,
  input  logic              cpu_resp_ready,
  output logic [DATA_W-1:0] cpu_resp_rdata,
  output logic              cpu_resp_err,
  input  logic              dma_req_valid,
  output logic              dma_req_ready,
  input  logic              dma_req_we,
  input  logic [ADDR_W-1:0] dma_req_addr,
  input  logic [DATA_W-1:0] dma_req_wdata,
  output logic              dma_resp_valid,
  input  logic              dma_resp_ready,
  output logic [DATA_W-1:0] dma_resp_rdata,
  output logic              dma_resp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e            state_q;
  logic              owner_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  logic accept_en, grant_cpu, grant_dma;
  logic misalign, in_access, mem_en, resp_hs;

  // Reset gates acceptance so no ready escapes while the block is held in reset.
  assign accept_en = (state_q == ST_IDLE) && !reset;

  dmem_arb_pick #(.STARVE_LIMIT(STARVE_LIMIT)) u_pick (
    .clk          (clk),
    .reset        (reset),
    .accept_en    (accept_en),
    .cpu_req_valid(cpu_req_valid),
    .dma_req_valid(dma_req_valid),
    .grant_cpu    (grant_cpu),
    .grant_dma    (grant_dma)
  );

  assign cpu_req_ready = grant_cpu;
  assign dma_req_ready = grant_dma;

`ifdef DMEM_ARB_MISALIGN_CHK_EN
  assign misalign = (addr_q[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  assign in_access = (state_q == ST_ACCESS);
  assign mem_en    = in_access && !misalign;
  assign mem_read  = mem_en && !we_q;
  assign mem_write = mem_en && we_q;
  assign mem_addr  = in_access ? addr_q  : '0;
  assign mem_wdata = in_access ? wdata_q : '0;

  assign cpu_resp_valid = (state_q == ST_RESP) && (owner_q == OWN_CPU);
  assign dma_resp_valid = (state_q == ST_RESP) && (owner_q == OWN_DMA);
  assign cpu_resp_rdata = cpu_resp_valid ? rdata_q : '0;
  assign dma_resp_rdata = dma_resp_valid ? rdata_q : '0;
  assign cpu_resp_err   = cpu_resp_valid && err_q;
  assign dma_resp_err   = dma_resp_valid && err_q;
  assign resp_hs        = (cpu_resp_valid && cpu_resp_ready) || (dma_resp_valid && dma_resp_ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_CPU;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant_cpu || grant_dma) begin
            owner_q <= grant_dma ? OWN_DMA       : OWN_CPU;
            we_q    <= grant_dma ? dma_req_we    : cpu_req_we;
            addr_q  <= grant_dma ? dma_req_addr  : cpu_req_addr;
            wdata_q <= grant_dma ? dma_req_wdata : cpu_req_wdata;
            state_q <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          rdata_q <= (we_q || misalign) ? '0 : mem_rdata;
          err_q   <= misalign;
          state_q <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_hs) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized traffic against
// a grant-sequence/shadow-memory model. Honours DMEM_ARB_MISALIGN_CHK_EN when defined.
module tb_dmem_arbiter;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;
  localparam int LIMIT  = 4;

  logic              clk, reset;
  logic              cpu_req_valid, cpu_req_ready, cpu_req_we;
  logic [ADDR_W-1:0] cpu_req_addr;
  logic [DATA_W-1:0] cpu_req_wdata;
  logic              cpu_resp_valid, cpu_resp_ready, cpu_resp_err;
  logic [DATA_W-1:0] cpu_resp_rdata;
  logic              dma_req_valid, dma_req_ready, dma_req_we;
  logic [ADDR_W-1:0] dma_req_addr;
  logic [DATA_W-1:0] dma_req_wdata;
  logic              dma_resp_valid, dma_resp_ready, dma_resp_err;
  logic [DATA_W-1:0] dma_resp_rdata;
  logic              mem_read, mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready), .cpu_req_we(cpu_req_we),
    .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata),
    .cpu_resp_valid(cpu_resp_valid), .cpu_resp_ready(cpu_resp_ready),
    .cpu_resp_rdata(cpu_resp_rdata), .cpu_resp_err(cpu_resp_err),
    .dma_req_valid(dma_req_valid), .dma_req_ready(dma_req_ready), .dma_req_we(dma_req_we),
    .dma_req_addr(dma_req_addr), .dma_req_wdata(dma_req_wdata),
    .dma_resp_valid(dma_resp_valid), .dma_resp_ready(dma_resp_ready),
    .dma_resp_rdata(dma_resp_rdata), .dma_resp_err(dma_resp_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Environment memory (what the DUT actually writes) and the bench's expected contents.
  logic [31:0] mem_arr [128];
  logic [31:0] shadow  [128];
  logic        mem_init;
  int          cyc;
  int          checks = 0;
  int          errors = 0;
  int          streak = 0;

  function automatic logic [31:0] init_word(int i);
    return 32'hA500_0000 | 32'(i * 4);
  endfunction

  assign mem_rdata = mem_arr[mem_addr[8:2]];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 128; i++) mem_arr[i] <= init_word(i);
    end else if (mem_write) begin
      mem_arr[mem_addr[8:2]] <= mem_wdata;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bit misal_f(logic [8:0] a);
`ifdef DMEM_ARB_MISALIGN_CHK_EN
    return a[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; any cycle seen without a pending DMA request resets the CPU streak.
  task automatic tick();
    @(posedge clk);
    if (!dma_req_valid) streak = 0;
    #1;
  endtask

  task automatic txn(input bit c_on, input bit d_on,
                     input logic c_we, input logic [8:0] c_addr, input logic [31:0] c_wd,
                     input logic d_we, input logic [8:0] d_addr, input logic [31:0] d_wd,
                     input int delay, input bit last, output bit got_dma, output int acc_cyc);
    bit exp_dma, exp_cpu, we, bad;
    logic [8:0]  addr;
    logic [31:0] wd, exp_rd;
    cpu_req_valid = c_on; cpu_req_we = c_we; cpu_req_addr = c_addr; cpu_req_wdata = c_wd;
    dma_req_valid = d_on; dma_req_we = d_we; dma_req_addr = d_addr; dma_req_wdata = d_wd;
    @(negedge clk);
    exp_dma = d_on && (!c_on || streak >= LIMIT);
    exp_cpu = c_on && !exp_dma;
    check("idle_cpu_ready", cpu_req_ready, exp_cpu);
    check("idle_dma_ready", dma_req_ready, exp_dma);
    got_dma = exp_dma;
    acc_cyc = cyc;
    we   = exp_dma ? d_we   : c_we;
    addr = exp_dma ? d_addr : c_addr;
    wd   = exp_dma ? d_wd   : c_wd;
    if (exp_dma) streak = 0;
    else if (d_on) streak = (streak < LIMIT) ? streak + 1 : LIMIT;
    bad    = misal_f(addr);
    exp_rd = (we || bad) ? 32'h0 : shadow[addr[8:2]];
    if (we && !bad) shadow[addr[8:2]] = wd;
    tick();
    // Scramble the request side; the latched transaction must not notice.
    cpu_req_we = 1'($urandom); cpu_req_addr = 9'($urandom); cpu_req_wdata = $urandom;
    dma_req_we = 1'($urandom); dma_req_addr = 9'($urandom); dma_req_wdata = $urandom;
    if (exp_dma) cpu_resp_ready = 1'b1; else dma_resp_ready = 1'b1;
    @(negedge clk);
    check("acc_cpu_ready", cpu_req_ready, 1'b0);
    check("acc_dma_ready", dma_req_ready, 1'b0);
    check("acc_mem_read",  mem_read,  !we && !bad);
    check("acc_mem_write", mem_write, we && !bad);
    check("acc_mem_addr",  mem_addr,  addr);
    check("acc_mem_wdata", mem_wdata, wd);
    check("acc_resp_valid", {cpu_resp_valid, dma_resp_valid}, 2'b00);
    tick();
    for (int i = 0; i <= delay; i++) begin
      @(negedge clk);
      check("resp_cpu_valid", cpu_resp_valid, !exp_dma);
      check("resp_dma_valid", dma_resp_valid, exp_dma);
      check("resp_rdata", exp_dma ? dma_resp_rdata : cpu_resp_rdata, exp_rd);
      check("resp_err",   exp_dma ? dma_resp_err   : cpu_resp_err,   bad);
      check("resp_req_ready", {cpu_req_ready, dma_req_ready}, 2'b00);
      check("resp_strobes", {mem_read, mem_write}, 2'b00);
      if (i == delay) begin
        if (exp_dma) dma_resp_ready = 1'b1; else cpu_resp_ready = 1'b1;
        if (last) begin cpu_req_valid = 1'b0; dma_req_valid = 1'b0; end
      end
      tick();
    end
    cpu_resp_ready = 1'b0;
    dma_resp_ready = 1'b0;
  endtask

  task automatic rand_txn(input bit c_on, input bit d_on, input int max_delay, input bit last,
                          output bit got_dma, output int acc_cyc);
    logic [31:0] r1, r2;
    logic [8:0]  a1, a2;
    r1 = $urandom; r2 = $urandom;
    a1 = {r1[8:2], (r1[13:12] == 2'b00) ? r1[1:0] : 2'b00};
    a2 = {r2[8:2], (r2[13:12] == 2'b00) ? r2[1:0] : 2'b00};
    txn(c_on, d_on, r1[20], a1, $urandom, r2[20], a2, $urandom,
        $urandom_range(0, max_delay), last, got_dma, acc_cyc);
  endtask

  bit got;
  int acc, acc_prev;
  logic [31:0] r;

  initial begin
    reset = 1'b1; mem_init = 1'b1;
    cpu_req_valid = 1'b1; cpu_req_we = 1'b0; cpu_req_addr = '0; cpu_req_wdata = '0;
    dma_req_valid = 1'b1; dma_req_we = 1'b0; dma_req_addr = '0; dma_req_wdata = '0;
    cpu_resp_ready = 1'b0; dma_resp_ready = 1'b0;
    for (int i = 0; i < 128; i++) shadow[i] = init_word(i);
    repeat (2) @(negedge clk);
    check("rst_req_ready", {cpu_req_ready, dma_req_ready}, 2'b00);
    check("rst_resp_valid", {cpu_resp_valid, dma_resp_valid}, 2'b00);
    check("rst_strobes", {mem_read, mem_write}, 2'b00);
    check("rst_mem_addr", mem_addr, 9'h0);
    check("rst_rdata_err", {cpu_resp_rdata, dma_resp_rdata, cpu_resp_err, dma_resp_err}, 66'h0);
    cpu_req_valid = 1'b0; dma_req_valid = 1'b0; mem_init = 1'b0;
    reset = 1'b0;
    tick();

    // Write then read back one word.
    txn(1, 0, 1'b1, 9'h010, 32'hDEADBEEF, 1'b0, 9'h0, 32'h0, 0, 1, got, acc);
    tick();
    txn(1, 0, 1'b0, 9'h010, 32'h0, 1'b0, 9'h0, 32'h0, 0, 1, got, acc);
    check("t1_mem_word", mem_arr[4], 32'hDEADBEEF);
    tick();

    // Both requesters hold valid: DMA forced in every fifth grant.
    for (int i = 0; i < 10; i++) begin
      rand_txn(1, 1, 0, i == 9, got, acc);
      check("t2_grant_is_dma", got, (i % 5) == 4);
    end
    tick();

    // Response back-pressure, then an immediate follow-up grant.
    txn(1, 0, 1'b0, 9'h040, 32'h0, 1'b0, 9'h0, 32'h0, 5, 0, got, acc);
    txn(1, 0, 1'b0, 9'h044, 32'h0, 1'b0, 9'h0, 32'h0, 0, 1, got, acc);
    tick();

    // Reset during the access cycle of a write.
    cpu_req_valid = 1'b1; cpu_req_we = 1'b1; cpu_req_addr = 9'h024; cpu_req_wdata = 32'h12345678;
    @(negedge clk);
    check("t4_ready", cpu_req_ready, 1'b1);
    tick();
    cpu_req_valid = 1'b0;
    @(negedge clk);
    check("t4_write_before", mem_write, 1'b1);
    #1 reset = 1'b1;
    #1;
    check("t4_write_dropped", {mem_read, mem_write}, 2'b00);
    check("t4_mem_addr", mem_addr, 9'h0);
    check("t4_mem_wdata", mem_wdata, 32'h0);
    check("t4_resp_valid", {cpu_resp_valid, dma_resp_valid}, 2'b00);
    tick();
    @(negedge clk);
    check("t4_mem_unchanged", mem_arr[9], shadow[9]);
    reset = 1'b0;
    streak = 0;
    tick();
    txn(1, 0, 1'b0, 9'h024, 32'h0, 1'b0, 9'h0, 32'h0, 0, 1, got, acc);
    tick();

    // Misaligned read and write.
    txn(1, 0, 1'b0, 9'h013, 32'h0, 1'b0, 9'h0, 32'h0, 1, 1, got, acc);
    tick();
    txn(1, 0, 1'b1, 9'h026, 32'hCAFEF00D, 1'b0, 9'h0, 32'h0, 0, 1, got, acc);
    tick();
    txn(0, 1, 1'b0, 9'h0, 32'h0, 1'b0, 9'h024, 32'h0, 0, 1, got, acc);
    tick();

    // DMA-only stream: one accept every three cycles.
    txn(0, 1, 1'b0, 9'h0, 32'h0, 1'b0, 9'h100, 32'h0, 0, 0, got, acc_prev);
    for (int i = 0; i < 2; i++) begin
      txn(0, 1, 1'b0, 9'h0, 32'h0, 1'b0, 9'(9'h104 + 4 * i), 32'h0, 0, i == 1, got, acc);
      check("t6_period", acc - acc_prev, 3);
      acc_prev = acc;
    end
    for (int i = 0; i < 5; i++) begin
      rand_txn(1, 1, 0, i == 4, got, acc);
      check("t6_grant_is_dma", got, i == 4);
    end
    tick();

    // Randomized traffic against the model.
    for (int i = 0; i < 40; i++) begin
      r = $urandom;
      rand_txn(r[0] | ~r[1], r[1], 2, i == 39, got, acc);
    end
    tick();
    for (int i = 0; i < 128; i++) begin
      if (mem_arr[i] !== shadow[i]) check("final_mem_word", mem_arr[i], shadow[i]);
    end
    check("final_mem_word4", mem_arr[4], shadow[4]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
